// File: rtl/wishbone_p2p_slave_mem_if.sv
// Wishbone point-to-point bus bundle for a single master / single slave pair.
// Handshake: a transfer is requested while cyc&stb are high and ends on the one cycle where exactly one of ack/err/rty is high.
interface wishbone_p2p_slave_mem_if #(
  parameter int data_width = 32,
  parameter int addr_width = 32
);
  logic [addr_width-1:0] adr;
  logic [data_width-1:0] wdata;
  logic [7:0]            sel;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  lock;
  logic                  busy;
  logic [data_width-1:0] rdata;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output adr, wdata, sel, cyc, stb, we, lock, busy,
    input  rdata, ack, err, rty
  );

  modport slave (
    input  adr, wdata, sel, cyc, stb, we, lock, busy,
    output rdata, ack, err, rty
  );
endinterface

// File: rtl/wishbone_p2p_slave_mem.sv
// Wishbone classic slave with an internal word memory, byte-lane writes,
// programmable wait states and err/rty termination.
module wishbone_p2p_slave_mem #(
  parameter int                     data_width  = 32,
  parameter int                     addr_width  = 32,
  parameter int                     mem_words   = 256,
  parameter logic [addr_width-1:0]  base_addr   = '0,
  parameter int                     wait_states = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  wishbone_p2p_slave_mem_if.slave        bus,
  output logic [1:0]                     dbg_state
);
  localparam int bytes = data_width / 8;
  localparam int lsb   = $clog2(bytes);
  localparam int iw    = $clog2(mem_words);
  localparam logic [addr_width:0]   span       = (addr_width + 1)'(mem_words * bytes);
  localparam logic [addr_width:0]   base_ext   = {1'b0, base_addr};
  localparam logic [addr_width-1:0] align_mask = addr_width'(bytes - 1);
  localparam logic [3:0]            ws         = 4'(wait_states);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {R_ACK = 2'd0, R_ERR = 2'd1, R_RTY = 2'd2} resp_t;

  state_t state, state_n;
  resp_t  kind, kind_n;
  logic [3:0] cnt, cnt_n;
  logic       fire;

  logic [data_width-1:0] mem [mem_words];
  logic [data_width-1:0] rdata_q;
  logic [iw-1:0]         lat_idx;
  logic                  lat_we;
  logic [bytes-1:0]      lat_sel;
  logic [data_width-1:0] lat_wdata;

  logic [addr_width:0]   off;
  logic                  bad;
  logic                  accept;
  logic                  hold;
  logic [iw-1:0]         idx_in;
  logic [iw-1:0]         cur_idx;
  logic                  cur_we;
  logic [bytes-1:0]      cur_sel;
  logic [data_width-1:0] cur_wdata;
  logic                  unused_ok;

  // Range check runs one bit wider than the address so that adr < base_addr
  // shows up as an out-of-range offset instead of wrapping into the window.
  assign off    = {1'b0, bus.adr} - base_ext;
  assign bad    = ((bus.adr & align_mask) != '0) || ({1'b0, bus.adr} < base_ext) || (off >= span);
  assign idx_in = off[lsb +: iw];
  assign hold   = bus.cyc && bus.stb;
  assign accept = (state == S_IDLE) && hold;

  // With zero wait states the ack edge is the accept edge, so the bus
  // fields are used directly; otherwise the latched copies are.
  assign cur_idx   = (state == S_IDLE) ? idx_in                : lat_idx;
  assign cur_we    = (state == S_IDLE) ? bus.we                : lat_we;
  assign cur_sel   = (state == S_IDLE) ? bus.sel[bytes-1:0]    : lat_sel;
  assign cur_wdata = (state == S_IDLE) ? bus.wdata             : lat_wdata;

  assign unused_ok = ^{bus.lock, bus.sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      kind    <= R_ACK;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      kind  <= kind_n;
      cnt   <= cnt_n;
      if (fire && !cur_we) rdata_q <= mem[cur_idx];
    end
    if (accept) begin
      lat_idx   <= idx_in;
      lat_we    <= bus.we;
      lat_sel   <= bus.sel[bytes-1:0];
      lat_wdata <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fire && cur_we) begin
      for (int i = 0; i < bytes; i++) begin
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_n = state;
    kind_n  = kind;
    cnt_n   = cnt;
    fire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad) begin
            state_n = S_RESP;
            kind_n  = R_ERR;
          end else if (bus.busy) begin
            state_n = S_RESP;
            kind_n  = R_RTY;
          end else if (ws == 4'd0) begin
            state_n = S_RESP;
            kind_n  = R_ACK;
            fire    = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = ws;
          end
        end
      end
      S_WAIT: begin
        if (!hold) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == 4'd1) begin
          state_n = S_RESP;
          kind_n  = R_ACK;
          cnt_n   = '0;
          fire    = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack   = (state == S_RESP) && (kind == R_ACK);
    bus.err   = (state == S_RESP) && (kind == R_ERR);
    bus.rty   = (state == S_RESP) && (kind == R_RTY);
    bus.rdata = rdata_q;
    dbg_state = state;
  end
endmodule

// File: tb/tb_wishbone_p2p_slave_mem.sv
// Bench for wishbone_p2p_slave_mem: two instances (ws=1 base 0, ws=3 base 0x1000),
// directed vector table, abort/reset sequences and randomized traffic vs a byte-level model.
module tb_wishbone_p2p_slave_mem;
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_ACK  = 3'b100;
  localparam logic [2:0] T_ERR  = 3'b010;
  localparam logic [2:0] T_RTY  = 3'b001;

  int unsigned base_v [2] = '{32'h0, 32'h1000};
  int          ws_v   [2] = '{1, 3};

  logic clk;
  logic rst;
  logic [1:0] dbg0, dbg1;

  logic [31:0] adr_v   [2];
  logic [31:0] wdata_v [2];
  logic [7:0]  sel_v   [2];
  logic        cyc_v   [2];
  logic        stb_v   [2];
  logic        we_v    [2];
  logic        lock_v  [2];
  logic        busy_v  [2];

  wishbone_p2p_slave_mem_if #(.data_width(32), .addr_width(32)) if0 ();
  wishbone_p2p_slave_mem_if #(.data_width(32), .addr_width(32)) if1 ();

  assign if0.adr = adr_v[0];  assign if0.wdata = wdata_v[0]; assign if0.sel  = sel_v[0];
  assign if0.cyc = cyc_v[0];  assign if0.stb   = stb_v[0];   assign if0.we   = we_v[0];
  assign if0.lock = lock_v[0]; assign if0.busy = busy_v[0];
  assign if1.adr = adr_v[1];  assign if1.wdata = wdata_v[1]; assign if1.sel  = sel_v[1];
  assign if1.cyc = cyc_v[1];  assign if1.stb   = stb_v[1];   assign if1.we   = we_v[1];
  assign if1.lock = lock_v[1]; assign if1.busy = busy_v[1];

  wishbone_p2p_slave_mem #(
    .data_width(32), .addr_width(32), .mem_words(256), .base_addr(32'h0), .wait_states(1)
  ) u0 (.clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0));

  wishbone_p2p_slave_mem #(
    .data_width(32), .addr_width(32), .mem_words(256), .base_addr(32'h1000), .wait_states(3)
  ) u1 (.clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // reference model: byte image of each memory window plus last read word
  logic [7:0]  mbytes [2][1024];
  logic [31:0] mrd    [2];

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [7:0]  sel;
    bit          busy;
    logic [2:0]  term;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [16];

  function automatic logic [2:0] term_of(input int d);
    return (d == 0) ? {if0.ack, if0.err, if0.rty} : {if1.ack, if1.err, if1.rty};
  endfunction

  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? if0.rdata : if1.rdata;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic mdl(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [7:0] s, input bit b,
                     output logic [2:0] ek, output int el, output logic [31:0] er);
    int unsigned off;
    off = a - base_v[d];
    if (a[1:0] != 2'b00 || a < base_v[d] || off >= 1024) begin
      ek = T_ERR;
      el = 1;
    end else if (b) begin
      ek = T_RTY;
      el = 1;
    end else begin
      ek = T_ACK;
      el = ws_v[d] + 1;
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (s[i]) mbytes[d][off + i] = wd[8*i +: 8];
        end
      end else begin
        mrd[d] = {mbytes[d][off + 3], mbytes[d][off + 2], mbytes[d][off + 1], mbytes[d][off]};
      end
    end
    er = mrd[d];
  endtask

  task automatic drive(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [7:0] s, input bit b);
    adr_v[d] = a; wdata_v[d] = wd; sel_v[d] = s; we_v[d] = w; busy_v[d] = b;
    lock_v[d] = 1'($urandom_range(0, 1));
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1;
  endtask

  task automatic release_bus(input int d);
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0; busy_v[d] = 1'b0;
  endtask

  // One complete transfer; accept happens on the posedge after the drive.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [7:0] s, input bit b, input logic [2:0] ek, input int el,
                      input logic [31:0] er, input string nm);
    int n;
    logic [2:0] t;
    @(negedge clk);
    drive(d, w, a, wd, s, b);
    n = 0;
    t = T_NONE;
    while (t == T_NONE && n < 24) begin
      @(negedge clk);
      n++;
      t = term_of(d);
    end
    release_bus(d);
    chk({nm, " term"}, {29'd0, t}, {29'd0, ek});
    if (t != T_NONE) chk({nm, " latency"}, n, el);
    @(negedge clk);
    chk({nm, " single"}, {29'd0, term_of(d)}, {29'd0, T_NONE});
    chk({nm, " rdata"}, rd_of(d), er);
  endtask

  task automatic mxfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [7:0] s, input bit b, input string nm);
    logic [2:0] ek;
    int el;
    logic [31:0] er;
    mdl(d, w, a, wd, s, b, ek, el, er);
    xfer(d, w, a, wd, s, b, ek, el, er, nm);
  endtask

  task automatic chk_quiet(input int cycles, input string nm);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk({nm, " quiet0"}, {29'd0, term_of(0)}, {29'd0, T_NONE});
      chk({nm, " quiet1"}, {29'd0, term_of(1)}, {29'd0, T_NONE});
    end
  endtask

  function automatic logic [31:0] rand_adr(input int d);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return base_v[d] + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
    if (r == 1 && d == 0) return 32'h400 + 4 * $urandom_range(0, 4095);
    if (r == 1) return (d == 1 && $urandom_range(0, 1) == 0) ? 4 * $urandom_range(0, 1023)
                                                            : 32'h1400 + 4 * $urandom_range(0, 255);
    return base_v[d] + 4 * $urandom_range(0, 255);
  endfunction

  initial begin
    logic [2:0] ek;
    int el;
    logic [31:0] er;
    logic [31:0] old_word;

    for (int d = 0; d < 2; d++) begin
      release_bus(d);
      adr_v[d] = '0; wdata_v[d] = '0; sel_v[d] = '0; we_v[d] = 1'b0; lock_v[d] = 1'b0;
      mrd[d] = '0;
    end

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 8'h0F, 1'b0, T_ACK, 2, 32'h00000000};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h14,  32'h11223344, 8'h0F, 1'b0, T_ACK, 2, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 32'h14,  32'hAABBCCDD, 8'h05, 1'b0, T_ACK, 2, 32'hDEADBEEF};
    vt[4]  = '{1'b0, 32'h14,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'h11BB33DD};
    vt[5]  = '{1'b0, 32'h402, 32'h0,        8'h0F, 1'b0, T_ERR, 1, 32'h11BB33DD};
    vt[6]  = '{1'b0, 32'h400, 32'h0,        8'h0F, 1'b0, T_ERR, 1, 32'h11BB33DD};
    vt[7]  = '{1'b1, 32'h20,  32'hCAFEF00D, 8'h0F, 1'b0, T_ACK, 2, 32'h11BB33DD};
    vt[8]  = '{1'b1, 32'h20,  32'h55667788, 8'h0F, 1'b1, T_RTY, 1, 32'h11BB33DD};
    vt[9]  = '{1'b0, 32'h20,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'hCAFEF00D};
    vt[10] = '{1'b1, 32'h20,  32'h55667788, 8'h0F, 1'b0, T_ACK, 2, 32'hCAFEF00D};
    vt[11] = '{1'b0, 32'h20,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'h55667788};
    vt[12] = '{1'b1, 32'h10,  32'h00000000, 8'h00, 1'b0, T_ACK, 2, 32'h55667788};
    vt[13] = '{1'b0, 32'h10,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'hDEADBEEF};
    vt[14] = '{1'b1, 32'h11,  32'hFFFFFFFF, 8'h0F, 1'b0, T_ERR, 1, 32'hDEADBEEF};
    vt[15] = '{1'b0, 32'h10,  32'h0,        8'h0F, 1'b0, T_ACK, 2, 32'hDEADBEEF};

    // reset held for 5 cycles, outputs quiet throughout
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("reset%0d", i), {29'd0, term_of(0)}, {29'd0, T_NONE});
      chk($sformatf("reset%0d rdata0", i), rd_of(0), 32'h0);
      chk($sformatf("reset%0d rdata1", i), rd_of(1), 32'h0);
    end
    rst = 1'b0;
    chk_quiet(2, "post_reset");
    chk("post_reset rdata1", rd_of(1), 32'h0);

    // fill both memories so the model knows every word
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        mxfer(d, 1'b1, base_v[d] + 4 * i, $urandom, 8'h0F, 1'b0, $sformatf("init%0d_%0d", d, i));
      end
    end

    // directed vectors on the ws=1 instance
    for (int i = 0; i < 16; i++) begin
      mdl(0, vt[i].we, vt[i].adr, vt[i].wdata, vt[i].sel, vt[i].busy, ek, el, er);
      xfer(0, vt[i].we, vt[i].adr, vt[i].wdata, vt[i].sel, vt[i].busy,
           vt[i].term, vt[i].lat, vt[i].rd, $sformatf("vec%0d", i));
    end

    // abort: cyc dropped one cycle after accept in a 3-wait-state write
    old_word = {mbytes[1][32'h43], mbytes[1][32'h42], mbytes[1][32'h41], mbytes[1][32'h40]};
    @(negedge clk);
    drive(1, 1'b1, 32'h1040, ~old_word, 8'h0F, 1'b0);
    @(negedge clk);
    chk("abort wait", {29'd0, term_of(1)}, {29'd0, T_NONE});
    release_bus(1);
    chk_quiet(6, "abort");
    mxfer(1, 1'b0, 32'h1040, 32'h0, 8'h0F, 1'b0, "abort readback");
    chk("abort old data", rd_of(1), old_word);

    // reset during WAIT: no response, no write, rdata cleared
    @(negedge clk);
    drive(1, 1'b1, 32'h1040, ~old_word, 8'h0F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    release_bus(1);
    chk_quiet(2, "rst_wait");
    rst = 1'b0;
    mrd[0] = '0;
    mrd[1] = '0;
    chk_quiet(5, "rst_wait_after");
    chk("rst_wait rdata", rd_of(1), 32'h0);
    mxfer(1, 1'b0, 32'h1040, 32'h0, 8'h0F, 1'b0, "rst_wait readback");
    chk("rst_wait old data", rd_of(1), old_word);

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      int d;
      d = $urandom_range(0, 1);
      mxfer(d, 1'($urandom_range(0, 1)), rand_adr(d), $urandom, 8'($urandom),
            ($urandom_range(0, 7) == 0), $sformatf("rnd%0d_d%0d", i, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
